// File: rtl/input_arbiter.sv
// Arbitrates two requesters (CPU MMIO load, syscall read) for the user-input unit
// and returns keypad/switch data, or a forced zero response on WAIT timeout.
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif

module input_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req,
  output logic                   input_enable,
  input  logic                   input_complete,
  input  logic [`ISA_WIDTH-1:0]  keypad_data,
  input  logic                   switch_enable,
  input  logic [15:0]            switch_data,
  input  logic                   used_pause,
  output logic [1:0]             grant,
  output logic                   busy,
  output logic [1:0]             rsp_valid,
  output logic [`ISA_WIDTH-1:0]  rsp_data,
  output logic                   rsp_timeout
);

  localparam int W = `ISA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CLR, WAIT, RESPOND} state_t;

  state_t               state_q, state_d;
  logic [1:0]           grant_d, pick;
  logic                 busy_d, ie_d, to_d;
  logic [1:0]           rv_d;
  logic [W-1:0]         data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 prio_q, prio_d;   // 1: requester 1 wins the next tie
  logic                 timeout_hit;

  always_comb begin
    pick = req;
    if (req == 2'b11) pick = prio_q ? 2'b10 : 2'b01;
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !used_pause && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant;
    busy_d  = busy;
    ie_d    = 1'b0;
    rv_d    = '0;
    data_d  = rsp_data;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          state_d = ISSUE;
          grant_d = pick;
          busy_d  = 1'b1;
          ie_d    = 1'b1;
          prio_d  = pick[0];
        end
      end
      ISSUE: state_d = WAIT_CLR;
      WAIT_CLR: begin
        if (!input_complete) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // complete takes precedence over a coincident timeout
        if (input_complete) begin
          state_d = RESPOND;
          rv_d    = grant;
          data_d  = switch_enable ? W'(switch_data) : keypad_data;
        end else if (timeout_hit) begin
          state_d = RESPOND;
          rv_d    = grant;
          data_d  = '0;
          to_d    = 1'b1;
        end else if (!used_pause) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      RESPOND: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant        <= '0;
      busy         <= 1'b0;
      input_enable <= 1'b0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_timeout  <= 1'b0;
      cnt_q        <= '0;
      prio_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant        <= grant_d;
      busy         <= busy_d;
      input_enable <= ie_d;
      rsp_valid    <= rv_d;
      rsp_data     <= data_d;
      rsp_timeout  <= to_d;
      cnt_q        <= cnt_d;
      prio_q       <= prio_d;
    end
  end

endmodule

// File: tb/tb_input_arbiter.sv
// Directed self-checking bench for input_arbiter (TIMEOUT_CYCLES=10, 32-bit data).
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif

module tb_input_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic        input_enable;
  logic        input_complete;
  logic [31:0] keypad_data;
  logic        switch_enable;
  logic [15:0] switch_data;
  logic        used_pause;
  logic [1:0]  grant;
  logic        busy;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_timeout;

  int n_checks = 0;
  int n_errors = 0;

  input_arbiter #(.TIMEOUT_CYCLES(10), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req(req), .input_enable(input_enable),
    .input_complete(input_complete), .keypad_data(keypad_data),
    .switch_enable(switch_enable), .switch_data(switch_data),
    .used_pause(used_pause), .grant(grant), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one complete-terminated transaction from IDLE with req already set.
  task automatic do_txn(input int eg, input int waits, input logic [31:0] kd,
                        input logic sw_en, input logic [15:0] sw, input logic [31:0] ed,
                        input bit drop, input logic [1:0] req_after);
    keypad_data   = kd;
    switch_enable = sw_en;
    switch_data   = sw;
    tick();
    check("issue_ie", 32'(input_enable), 1);
    check("issue_grant", 32'(grant), 32'(eg));
    check("issue_busy", 32'(busy), 1);
    tick();
    check("clr_ie", 32'(input_enable), 0);
    check("clr_grant", 32'(grant), 32'(eg));
    tick();
    if (drop) req = req & ~2'(eg);
    for (int i = 0; i < waits; i++) begin
      check("wait_rv", 32'(rsp_valid), 0);
      tick();
    end
    input_complete = 1'b1;
    tick();
    check("rsp_valid", 32'(rsp_valid), 32'(eg));
    check("rsp_data", rsp_data, ed);
    check("rsp_to", 32'(rsp_timeout), 0);
    check("rsp_grant", 32'(grant), 32'(eg));
    input_complete = 1'b0;
    req = req_after;
    tick();
    check("idle_rv", 32'(rsp_valid), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_grant", 32'(grant), 0);
    check("idle_hold", rsp_data, ed);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; input_complete = 1'b0; keypad_data = '0;
    switch_enable = 1'b0; switch_data = '0; used_pause = 1'b0;
    tick(); tick();
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ie", 32'(input_enable), 0);
    check("rst_rv", 32'(rsp_valid), 0);
    check("rst_data", rsp_data, 0);
    check("rst_to", 32'(rsp_timeout), 0);
    rst = 1'b0;

    // Tie from reset: requester 0 first, then 1, then 0 again
    req = 2'b11;
    do_txn(1, 3, 123, 1'b0, 16'h0, 123, 1'b0, 2'b11);
    do_txn(2, 1, 77, 1'b0, 16'h0, 77, 1'b0, 2'b11);
    do_txn(1, 0, 88, 1'b0, 16'h0, 88, 1'b0, 2'b00);

    // Switch source, owner drops req mid-transaction
    req = 2'b01;
    do_txn(1, 2, 7, 1'b1, 16'hA5A5, 32'h0000A5A5, 1'b1, 2'b00);

    // Timeout: 14 WAIT cycles, 4 of them paused
    req = 2'b10; keypad_data = 99; switch_enable = 1'b0;
    tick();
    check("to_ie", 32'(input_enable), 1);
    check("to_grant", 32'(grant), 2);
    tick(); tick();
    for (int i = 0; i < 14; i++) begin
      used_pause = (i >= 2 && i < 6);
      check("to_wait_rv", 32'(rsp_valid), 0);
      tick();
    end
    used_pause = 1'b0;
    check("to_rv", 32'(rsp_valid), 2);
    check("to_data", rsp_data, 0);
    check("to_flag", 32'(rsp_timeout), 1);
    req = 2'b00;
    tick();
    check("to_clear", 32'(rsp_timeout), 0);
    check("to_idle_busy", 32'(busy), 0);

    // Stale complete held across ISSUE
    input_complete = 1'b1; req = 2'b01; keypad_data = 55;
    tick();
    check("stale_ie", 32'(input_enable), 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("stale_rv", 32'(rsp_valid), 0);
      check("stale_busy", 32'(busy), 1);
      tick();
    end
    input_complete = 1'b0;
    tick();
    check("stale_wait_rv", 32'(rsp_valid), 0);
    input_complete = 1'b1;
    tick();
    check("stale_rsp_rv", 32'(rsp_valid), 1);
    check("stale_rsp_data", rsp_data, 55);
    input_complete = 1'b0; req = 2'b00;
    tick();

    // Last grant was 0; reset must restore preference for requester 0
    rst = 1'b1; req = 2'b11;
    tick();
    rst = 1'b0;
    tick();
    check("rst_rr_grant", 32'(grant), 1);
    rst = 1'b1; req = 2'b00;
    tick();
    rst = 1'b0;

    // Reset during WAIT aborts the transaction
    req = 2'b10;
    tick(); tick(); tick(); tick();
    check("abort_pre_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    check("abort_grant", 32'(grant), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_rv", 32'(rsp_valid), 0);
    check("abort_ie", 32'(input_enable), 0);
    check("abort_data", rsp_data, 0);
    rst = 1'b0;
    tick();
    check("rearb_ie", 32'(input_enable), 1);
    check("rearb_grant", 32'(grant), 2);
    tick();
    check("rearb_ie_pulse", 32'(input_enable), 0);
    check("rearb_rv", 32'(rsp_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
